axi3_slave_mem: RTL
===================

// Module: axi3_slave_mem
// PURPOSE
//  AXI3 responder: the slave end of the 5-channel AXI bus driven by the master VIP.
//  Accepts write/read bursts (FIXED/INCR/WRAP, 1-16 beats) into a byte-enabled
//  word memory and returns B and R responses. Used as the synthesizable DUT
//  end of the back-to-back bench and as the reference slave for the scoreboard.
// PARAMETERS
//  ADDR_W     32    address width (AWADDR/ARADDR)
//  DATA_W     32    data width; byte lanes = DATA_W/8 (WSTB width)
//  ID_W       4     transaction ID width (AWID/WID/BID/ARID/RID)
//  MEM_DEPTH  1024  memory words; byte addresses >= MEM_DEPTH*DATA_W/8 decode-error
// PORTS
//  ACLK     in   1         clock, all logic on rising edge
//  ARESET   in   1         asynchronous, active-low reset
//  AWID     in   ID_W      write address ID
//  AWADDR   in   ADDR_W    write start byte address
//  AWLEN    in   4         beats-1
//  AWSIZE   in   3         bytes/beat = 1<<AWSIZE
//  AWBURST  in   2         00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  AWVALID  in   1  / AWREADY out 1   write address handshake
//  WID      in   ID_W      write data ID
//  WDATA    in   DATA_W    write data
//  WSTB     in   DATA_W/8  byte strobes
//  WLAST    in   1         final write beat
//  WVALID   in   1  / WREADY  out 1   write data handshake
//  BID      out  ID_W      = latched AWID
//  BREP     out  2         00 OKAY, 10 SLVERR, 11 DECERR
//  BVALID   out  1  / BREADY  in  1   write response handshake
//  ARID, ARADDR, ARLEN, ARSIZE, ARBURST  in  as AW*;  ARVALID in 1 / ARREADY out 1
//  RID      out  ID_W      = latched ARID
//  RDATA    out  DATA_W    read data (0 on error beats)
//  RRESP    out  2         per-beat response, encoding as BREP
//  RLAST    out  1         final read beat
//  RVALID   out  1  / RREADY  in  1   read data handshake
// BEHAVIOUR
//  Reset (ARESET=0, async): all outputs 0, both FSMs to IDLE; memory not cleared.
//   Reset mid-burst aborts it silently; no B/R response is issued afterwards.
//  Write FSM W_IDLE->W_DATA->W_RESP:
//   W_IDLE: AWREADY=1 (first cycle after reset release). AWVALID&AWREADY latches
//    AW*, beat cnt=0, goes W_DATA next cycle (AWREADY=0).
//   W_DATA: WREADY=1; each WVALID&WREADY writes lanes with WSTB=1 to current word,
//    advances address, cnt++. Beat cnt==AWLEN -> W_RESP. WREADY=0 in W_RESP.
//   W_RESP: BVALID=1, BID, BREP held stable until BREADY; then W_IDLE.
//   BREP=SLVERR if AWSIZE>log2(DATA_W/8), AWBURST=11, WRAP with AWLEN not in
//    {1,3,7,15}, WLAST!=(cnt==AWLEN) on any beat, or WID!=AWID; writes still
//    complete beat count but memory is not modified. DECERR if any beat out of
//    range (that beat discarded). DECERR has priority over SLVERR.
//  Read FSM R_IDLE->R_DATA:
//   R_IDLE: ARREADY=1; handshake latches AR*. RVALID rises the next cycle with beat 0.
//   R_DATA: RDATA/RRESP/RLAST/RID stable while RVALID&!RREADY. On handshake next
//    beat presented the following cycle (back-to-back beats, 1/cycle). RLAST=1
//    on beat ARLEN; its handshake returns to R_IDLE, ARREADY=1 next cycle.
//   Error rules as write path, per beat, RDATA=0 on error beats.
//  Address generation (bytes B=1<<SIZE, mod 2^ADDR_W):
//   FIXED: all beats use start address. INCR: beat0=start, beat n=align(start,B)+n*B
//   (unaligned start: only beat0 unaligned). WRAP: boundary W=(LEN+1)*B,
//   lower=floor(start/W)*W; next=addr+B, if next==lower+W then next=lower.
//   Word index = addr/(DATA_W/8); memory indexed by word only.
//  Read and write FSMs independent, may run concurrently. Same-word read and
//   write in one cycle: read returns pre-write data. One outstanding per direction.
// TESTING
//  1 Reset: ARESET=0 mid-burst -> all outputs 0, AWREADY/ARREADY=1 one cycle after release.
//  2 INCR write AW=0x100,LEN=3,SIZE=2,ID=5, data 0xA0..0xA3, WSTB=F -> BID=5,BREP=00;
//    INCR read same -> RDATA A0,A1,A2,A3, RLAST on 4th, RID=5.
//  3 WRAP read AR=0x38,LEN=3,SIZE=2 -> words 0x38,0x3C,0x30,0x34.
//  4 Write 0x10 data 0xDEADBEEF WSTB=0101 over 0x0 -> read 0x00AD00EF.
//  5 RREADY low 3 cycles on beat 1 -> RDATA/RLAST stable; WLAST early on beat 2 of
//    LEN=3 -> BREP=10, memory unchanged; AWADDR=MEM_DEPTH*4 -> BREP=11.

Source files
------------

// File: rtl/axi3_slave_mem.sv
// axi3_slave_mem
//   AXI3 slave with a byte-enabled word memory. Accepts FIXED/INCR/WRAP bursts
//   of 1-16 beats on the write and read channels and returns B and R responses.
//   The write and read paths are independent FSMs and may run concurrently.
//
//   Write path: each accepted W beat is staged in a 16-entry buffer. When the
//   last beat arrives the buffer is drained into memory one word per cycle,
//   unless the burst earned SLVERR, in which case nothing is written. This lets
//   an error found on a late beat (bad WLAST, bad WID) leave memory untouched.
//   Out-of-range beats are staged but flagged so the drain skips them.
//
//   Read path: beat 0 is registered on the AR handshake and each following
//   beat is registered on the previous R handshake, so beats flow at 1/cycle.
//   A read of a word written in the same cycle returns the pre-write data.
//
// Ports
//   ACLK, ARESET              clock, async active-low reset
//   AW* / AWVALID / AWREADY   write address channel
//   W*  / WVALID  / WREADY    write data channel (WSTB = byte strobes)
//   BID, BREP / BVALID/BREADY write response (00 OKAY, 10 SLVERR, 11 DECERR)
//   AR* / ARVALID / ARREADY   read address channel
//   RID, RDATA, RRESP, RLAST / RVALID / RREADY   read data channel
//
// Write FSM states
//   W_IDLE   | AWREADY high, waiting for a write address
//   W_DATA   | WREADY high, staging beats into the buffer
//   W_COMMIT | draining staged beats into memory, one per cycle
//   W_RESP   | BVALID high until BREADY
// Read FSM states
//   R_IDLE   | ARREADY high, waiting for a read address
//   R_DATA   | RVALID high, presenting beats until the RLAST handshake

module axi3_slave_mem #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int ID_W      = 4,
   parameter int MEM_DEPTH = 1024
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic [ID_W-1:0]     AWID,
   input  logic [ADDR_W-1:0]   AWADDR,
   input  logic [3:0]          AWLEN,
   input  logic [2:0]          AWSIZE,
   input  logic [1:0]          AWBURST,
   input  logic                AWVALID,
   output logic                AWREADY,
   input  logic [ID_W-1:0]     WID,
   input  logic [DATA_W-1:0]   WDATA,
   input  logic [DATA_W/8-1:0] WSTB,
   input  logic                WLAST,
   input  logic                WVALID,
   output logic                WREADY,
   output logic [ID_W-1:0]     BID,
   output logic [1:0]          BREP,
   output logic                BVALID,
   input  logic                BREADY,
   input  logic [ID_W-1:0]     ARID,
   input  logic [ADDR_W-1:0]   ARADDR,
   input  logic [3:0]          ARLEN,
   input  logic [2:0]          ARSIZE,
   input  logic [1:0]          ARBURST,
   input  logic                ARVALID,
   output logic                ARREADY,
   output logic [ID_W-1:0]     RID,
   output logic [DATA_W-1:0]   RDATA,
   output logic [1:0]          RRESP,
   output logic                RLAST,
   output logic                RVALID,
   input  logic                RREADY
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_COMMIT, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

   // Burst-level protocol violations, known as soon as the address is accepted.
   function automatic logic burst_slv(input logic [2:0] size, input logic [1:0] burst,
                                      input logic [3:0] len);
      logic bad_wrap;
      bad_wrap  = (burst == 2'b10) &&
                  !((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15));
      burst_slv = (size > 3'(OFF_W)) || (burst == 2'b11) || bad_wrap;
   endfunction

   function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
      out_of_range = (a >> OFF_W) >= ADDR_W'(MEM_DEPTH);
   endfunction

   function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
      idx_of = IDX_W'(a >> OFF_W);
   endfunction

   // Address of the beat after 'a'. The WRAP lower bound is recomputed from the
   // current address each beat; it never changes within a legal wrap burst.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [2:0] size,
                                                   input logic [1:0] burst,
                                                   input logic [3:0] len);
      logic [ADDR_W-1:0] b;
      logic [ADDR_W-1:0] w;
      logic [ADDR_W-1:0] lower;
      logic [ADDR_W-1:0] nxt;
      b     = ADDR_W'(1) << size;
      w     = ADDR_W'({1'b0, len} + 5'd1) << size;
      lower = a & ~(w - ADDR_W'(1));
      nxt   = a + b;
      case (burst)
         2'b00:   next_addr = a;
         2'b10:   next_addr = (nxt == lower + w) ? lower : nxt;
         default: next_addr = (a & ~(b - ADDR_W'(1))) + b;
      endcase
   endfunction

   // ---------------- storage ----------------
   logic [DATA_W-1:0] mem_q     [MEM_DEPTH];
   logic [IDX_W-1:0]  wbuf_idx_q  [16];
   logic [DATA_W-1:0] wbuf_data_q [16];
   logic [NB-1:0]     wbuf_strb_q [16];
   logic              wbuf_ok_q   [16];

   logic              wbuf_we;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_widx;
   logic [DATA_W-1:0] mem_wdata;
   logic [NB-1:0]     mem_wstrb;

   // ---------------- write path state ----------------
   w_state_e          w_state_q, w_state_d;
   logic              awready_q, awready_d;
   logic              wready_q, wready_d;
   logic              bvalid_q, bvalid_d;
   logic [ID_W-1:0]   bid_q, bid_d;
   logic [1:0]        brep_q, brep_d;
   logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
   logic [3:0]        aw_len_q, aw_len_d;
   logic [2:0]        aw_size_q, aw_size_d;
   logic [1:0]        aw_burst_q, aw_burst_d;
   logic [ID_W-1:0]   aw_id_q, aw_id_d;
   logic [3:0]        wcnt_q, wcnt_d;
   logic              wslv_q, wslv_d;
   logic              wdec_q, wdec_d;

   logic aw_hs, w_hs, b_hs;
   logic w_beat_last, w_beat_slv, w_beat_dec;

   assign aw_hs       = AWVALID && awready_q;
   assign w_hs        = WVALID && wready_q;
   assign b_hs        = bvalid_q && BREADY;
   assign w_beat_last = (wcnt_q == aw_len_q);
   assign w_beat_slv  = wslv_q || (WLAST != w_beat_last) || (WID != aw_id_q);
   assign w_beat_dec  = out_of_range(aw_addr_q);

   assign mem_we    = (w_state_q == W_COMMIT) && wbuf_ok_q[wcnt_q];
   assign mem_widx  = wbuf_idx_q[wcnt_q];
   assign mem_wdata = wbuf_data_q[wcnt_q];
   assign mem_wstrb = wbuf_strb_q[wcnt_q];

   always_comb begin
      w_state_d  = w_state_q;
      bid_d      = bid_q;
      brep_d     = brep_q;
      aw_addr_d  = aw_addr_q;
      aw_len_d   = aw_len_q;
      aw_size_d  = aw_size_q;
      aw_burst_d = aw_burst_q;
      aw_id_d    = aw_id_q;
      wcnt_d     = wcnt_q;
      wslv_d     = wslv_q;
      wdec_d     = wdec_q;
      wbuf_we    = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs) begin
               aw_addr_d  = AWADDR;
               aw_len_d   = AWLEN;
               aw_size_d  = AWSIZE;
               aw_burst_d = AWBURST;
               aw_id_d    = AWID;
               wcnt_d     = 4'd0;
               wslv_d     = burst_slv(AWSIZE, AWBURST, AWLEN);
               wdec_d     = 1'b0;
               w_state_d  = W_DATA;
            end
         end
         W_DATA: begin
            if (w_hs) begin
               wbuf_we = 1'b1;
               wslv_d  = w_beat_slv;
               wdec_d  = wdec_q || w_beat_dec;
               if (w_beat_last) begin
                  bid_d = aw_id_q;
                  if (wdec_q || w_beat_dec) brep_d = RESP_DECERR;
                  else if (w_beat_slv)      brep_d = RESP_SLVERR;
                  else                      brep_d = RESP_OKAY;
                  wcnt_d    = 4'd0;
                  w_state_d = w_beat_slv ? W_RESP : W_COMMIT;
               end else begin
                  wcnt_d    = wcnt_q + 4'd1;
                  aw_addr_d = next_addr(aw_addr_q, aw_size_q, aw_burst_q, aw_len_q);
               end
            end
         end
         W_COMMIT: begin
            if (wcnt_q == aw_len_q) w_state_d = W_RESP;
            else                    wcnt_d    = wcnt_q + 4'd1;
         end
         W_RESP: begin
            if (b_hs) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
      awready_d = (w_state_d == W_IDLE);
      wready_d  = (w_state_d == W_DATA);
      bvalid_d  = (w_state_d == W_RESP);
   end

   // ---------------- read path state ----------------
   r_state_e          r_state_q, r_state_d;
   logic              arready_q, arready_d;
   logic              rvalid_q, rvalid_d;
   logic [ID_W-1:0]   rid_q, rid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;
   logic              rlast_q, rlast_d;
   logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
   logic [3:0]        ar_len_q, ar_len_d;
   logic [2:0]        ar_size_q, ar_size_d;
   logic [1:0]        ar_burst_q, ar_burst_d;
   logic              ar_slv_q, ar_slv_d;
   logic [3:0]        rcnt_q, rcnt_d;

   logic              ar_hs, r_hs, r_load, pres_slv, pres_dec;
   logic [ADDR_W-1:0] pres_addr;
   logic [DATA_W-1:0] pres_word;

   assign ar_hs = ARVALID && arready_q;
   assign r_hs  = rvalid_q && RREADY;

   always_comb begin
      r_state_d  = r_state_q;
      rid_d      = rid_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      rlast_d    = rlast_q;
      ar_addr_d  = ar_addr_q;
      ar_len_d   = ar_len_q;
      ar_size_d  = ar_size_q;
      ar_burst_d = ar_burst_q;
      ar_slv_d   = ar_slv_q;
      rcnt_d     = rcnt_q;
      r_load     = 1'b0;
      pres_addr  = ar_addr_q;
      pres_slv   = ar_slv_q;
      case (r_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               ar_len_d   = ARLEN;
               ar_size_d  = ARSIZE;
               ar_burst_d = ARBURST;
               ar_slv_d   = burst_slv(ARSIZE, ARBURST, ARLEN);
               rid_d      = ARID;
               rcnt_d     = 4'd0;
               rlast_d    = (ARLEN == 4'd0);
               pres_addr  = ARADDR;
               pres_slv   = burst_slv(ARSIZE, ARBURST, ARLEN);
               r_load     = 1'b1;
               r_state_d  = R_DATA;
            end
         end
         R_DATA: begin
            if (r_hs) begin
               if (rlast_q) begin
                  rlast_d   = 1'b0;
                  r_state_d = R_IDLE;
               end else begin
                  rcnt_d    = rcnt_q + 4'd1;
                  rlast_d   = ((rcnt_q + 4'd1) == ar_len_q);
                  pres_addr = next_addr(ar_addr_q, ar_size_q, ar_burst_q, ar_len_q);
                  r_load    = 1'b1;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      pres_dec  = out_of_range(pres_addr);
      pres_word = mem_q[idx_of(pres_addr)];
      if (r_load) begin
         ar_addr_d = pres_addr;
         rdata_d   = (pres_dec || pres_slv) ? '0 : pres_word;
         if (pres_dec)      rresp_d = RESP_DECERR;
         else if (pres_slv) rresp_d = RESP_SLVERR;
         else               rresp_d = RESP_OKAY;
      end
      arready_d = (r_state_d == R_IDLE);
      rvalid_d  = (r_state_d == R_DATA);
   end

   // ---------------- control flops ----------------
   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET) begin
         w_state_q  <= W_IDLE;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bid_q      <= '0;
         brep_q     <= '0;
         aw_addr_q  <= '0;
         aw_len_q   <= '0;
         aw_size_q  <= '0;
         aw_burst_q <= '0;
         aw_id_q    <= '0;
         wcnt_q     <= '0;
         wslv_q     <= 1'b0;
         wdec_q     <= 1'b0;
         r_state_q  <= R_IDLE;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rid_q      <= '0;
         rdata_q    <= '0;
         rresp_q    <= '0;
         rlast_q    <= 1'b0;
         ar_addr_q  <= '0;
         ar_len_q   <= '0;
         ar_size_q  <= '0;
         ar_burst_q <= '0;
         ar_slv_q   <= 1'b0;
         rcnt_q     <= '0;
      end else begin
         w_state_q  <= w_state_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bid_q      <= bid_d;
         brep_q     <= brep_d;
         aw_addr_q  <= aw_addr_d;
         aw_len_q   <= aw_len_d;
         aw_size_q  <= aw_size_d;
         aw_burst_q <= aw_burst_d;
         aw_id_q    <= aw_id_d;
         wcnt_q     <= wcnt_d;
         wslv_q     <= wslv_d;
         wdec_q     <= wdec_d;
         r_state_q  <= r_state_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rid_q      <= rid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         rlast_q    <= rlast_d;
         ar_addr_q  <= ar_addr_d;
         ar_len_q   <= ar_len_d;
         ar_size_q  <= ar_size_d;
         ar_burst_q <= ar_burst_d;
         ar_slv_q   <= ar_slv_d;
         rcnt_q     <= rcnt_d;
      end
   end

   // Staging buffer and memory are not reset; contents survive ARESET.
   always_ff @(posedge ACLK) begin
      if (wbuf_we) begin
         wbuf_idx_q[wcnt_q]  <= idx_of(aw_addr_q);
         wbuf_data_q[wcnt_q] <= WDATA;
         wbuf_strb_q[wcnt_q] <= WSTB;
         wbuf_ok_q[wcnt_q]   <= !w_beat_dec;
      end
   end

   always_ff @(posedge ACLK) begin
      if (mem_we) begin
         for (int i = 0; i < NB; i++) begin
            if (mem_wstrb[i]) mem_q[mem_widx][i*8 +: 8] <= mem_wdata[i*8 +: 8];
         end
      end
   end

   assign AWREADY = awready_q;
   assign WREADY  = wready_q;
   assign BVALID  = bvalid_q;
   assign BID     = bid_q;
   assign BREP    = brep_q;
   assign ARREADY = arready_q;
   assign RVALID  = rvalid_q;
   assign RID     = rid_q;
   assign RDATA   = rdata_q;
   assign RRESP   = rresp_q;
   assign RLAST   = rlast_q;

endmodule
